// File: rtl/lifo_fifo_ctrl_pkg.sv
// Shared types and constants for the lifo_fifo_ctrl block.
package lifo_fifo_pkg;

    typedef enum logic {
        MODE_FIFO = 1'b0,
        MODE_LIFO = 1'b1
    } lf_mode_t;

    typedef enum logic [1:0] {
        OP_NONE,
        OP_PUSH,
        OP_POP
    } lf_op_t;

    localparam logic MEM_WRITE = 1'b1;
    localparam logic MEM_READ  = 1'b0;

endpackage

// File: rtl/lifo_fifo_ctrl_if.sv
// Producer request/response bus plus single-port memory command bus.
// almost_full/almost_empty exist only when LIFO_FIFO_CTRL_ALMOST_EN is defined.
interface lifo_fifo_ctrl_if #(
    parameter int unsigned ADDR_W = 4,
    parameter int unsigned DATA_W = 32,
    parameter int unsigned CNT_W  = 3
) ();
    logic              mode;
    logic              push;
    logic [DATA_W-1:0] din;
    logic              pop;
    logic              push_rdy;
    logic              pop_rdy;
    logic [DATA_W-1:0] rd_data;
    logic              rd_valid;
    logic              full;
    logic              empty;
    logic [CNT_W-1:0]  count;
    logic              ovf;
    logic              udf;
    logic              clr_err;
    logic              mem_valid;
    logic              mem_r_w;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_din;
    logic [DATA_W-1:0] mem_dout;
`ifdef LIFO_FIFO_CTRL_ALMOST_EN
    logic              almost_full;
    logic              almost_empty;
`endif

    // Producer and memory side (drives requests, returns read data).
    modport master (
        output mode, push, din, pop, clr_err, mem_dout,
        input  push_rdy, pop_rdy, rd_data, rd_valid, full, empty, count,
               ovf, udf, mem_valid, mem_r_w, mem_addr, mem_din
`ifdef LIFO_FIFO_CTRL_ALMOST_EN
        , input almost_full, almost_empty
`endif
    );

    // Controller side.
    modport slave (
        input  mode, push, din, pop, clr_err, mem_dout,
        output push_rdy, pop_rdy, rd_data, rd_valid, full, empty, count,
               ovf, udf, mem_valid, mem_r_w, mem_addr, mem_din
`ifdef LIFO_FIFO_CTRL_ALMOST_EN
        , output almost_full, almost_empty
`endif
    );

endinterface

// File: rtl/lifo_fifo_ctrl_wrap_ptr.sv
// Modulo-DEPTH pointer with synchronous clear (priority) and increment.
module lf_wrap_ptr #(
    parameter int unsigned DEPTH = 4,
    parameter int unsigned W     = 4
) (
    input  logic         clk_i,
    input  logic         rst_ni,
    input  logic         clr_i,
    input  logic         inc_i,
    output logic [W-1:0] ptr_o
);
    logic [W-1:0] ptr_q, ptr_d;

    // Next pointer: clear wins, otherwise wrap DEPTH-1 -> 0 on increment.
    always_comb begin
        ptr_d = ptr_q;
        if (clr_i) begin
            ptr_d = '0;
        end else if (inc_i) begin
            ptr_d = (ptr_q == W'(DEPTH - 1)) ? '0 : ptr_q + 1'b1;
        end
    end

    // Pointer register.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) ptr_q <= '0;
        else         ptr_q <= ptr_d;
    end

    assign ptr_o = ptr_q;
endmodule

// File: rtl/lifo_fifo_ctrl.sv
// FIFO/LIFO control stage in front of a single-port memory: one command per
// cycle, pop has priority over push. Optional macro LIFO_FIFO_CTRL_ALMOST_EN
// adds AF_LEVEL/AE_LEVEL and almost_full/almost_empty.
module lifo_fifo_ctrl
    import lifo_fifo_pkg::*;
#(
    parameter int unsigned DEPTH  = 4,
    parameter int unsigned ADDR_W = 4,
    parameter int unsigned DATA_W = 32
`ifdef LIFO_FIFO_CTRL_ALMOST_EN
    ,
    parameter int unsigned AF_LEVEL = DEPTH - 1,
    parameter int unsigned AE_LEVEL = 1
`endif
) (
    input  logic               clk_i,
    input  logic               reset_ni,
    lifo_fifo_ctrl_if.slave    bus
);
    localparam int unsigned CNT_W = $clog2(DEPTH + 1);

    logic [CNT_W-1:0]  count_q, count_d;
    lf_mode_t          mode_q, mode_d;
    logic              rd_valid_q;
    logic              ovf_q, ovf_d, udf_q, udf_d;
    logic              empty, full, push_rdy, pop_rdy, mem_valid, ptr_clr;
    lf_op_t            op;
    logic [ADDR_W-1:0] wr_ptr, rd_ptr, mem_addr;

    // Arbitration and memory command; nothing is granted while in reset.
    always_comb begin
        empty    = (count_q == '0);
        full     = (count_q == CNT_W'(DEPTH));
        pop_rdy  = reset_ni & bus.pop & !empty;
        push_rdy = reset_ni & bus.push & !full & !pop_rdy;
        op       = pop_rdy ? OP_POP : (push_rdy ? OP_PUSH : OP_NONE);
        mem_valid = (op != OP_NONE);
        mem_addr = '0;
        case (op)
            OP_PUSH: mem_addr = (mode_q == MODE_LIFO) ? ADDR_W'(count_q) : wr_ptr;
            OP_POP:  mem_addr = (mode_q == MODE_LIFO) ? ADDR_W'(count_q - 1'b1) : rd_ptr;
            default: mem_addr = '0;
        endcase
    end

    // Next state for occupancy, mode latch and sticky error flags.
    always_comb begin
        count_d = count_q;
        if (push_rdy)     count_d = count_q + 1'b1;
        else if (pop_rdy) count_d = count_q - 1'b1;
        mode_d  = (empty && !mem_valid) ? lf_mode_t'(bus.mode) : mode_q;
        ptr_clr = (mode_d != mode_q);
        ovf_d   = bus.clr_err ? 1'b0 : ovf_q;
        if (bus.push && full && !pop_rdy) ovf_d = 1'b1;
        udf_d   = bus.clr_err ? 1'b0 : udf_q;
        if (bus.pop && empty) udf_d = 1'b1;
    end

    // State registers.
    always_ff @(posedge clk_i or negedge reset_ni) begin
        if (!reset_ni) begin
            count_q    <= '0;
            mode_q     <= MODE_FIFO;
            rd_valid_q <= 1'b0;
            ovf_q      <= 1'b0;
            udf_q      <= 1'b0;
        end else begin
            count_q    <= count_d;
            mode_q     <= mode_d;
            rd_valid_q <= pop_rdy;
            ovf_q      <= ovf_d;
            udf_q      <= udf_d;
        end
    end

    lf_wrap_ptr #(.DEPTH(DEPTH), .W(ADDR_W)) u_wr_ptr (
        .clk_i  (clk_i),
        .rst_ni (reset_ni),
        .clr_i  (ptr_clr),
        .inc_i  (push_rdy && (mode_q == MODE_FIFO)),
        .ptr_o  (wr_ptr)
    );

    lf_wrap_ptr #(.DEPTH(DEPTH), .W(ADDR_W)) u_rd_ptr (
        .clk_i  (clk_i),
        .rst_ni (reset_ni),
        .clr_i  (ptr_clr),
        .inc_i  (pop_rdy && (mode_q == MODE_FIFO)),
        .ptr_o  (rd_ptr)
    );

    assign bus.push_rdy  = push_rdy;
    assign bus.pop_rdy   = pop_rdy;
    assign bus.rd_data   = bus.mem_dout;
    assign bus.rd_valid  = rd_valid_q;
    assign bus.full      = full;
    assign bus.empty     = empty;
    assign bus.count     = count_q;
    assign bus.ovf       = ovf_q;
    assign bus.udf       = udf_q;
    assign bus.mem_valid = mem_valid;
    assign bus.mem_r_w   = (op == OP_PUSH) ? MEM_WRITE : MEM_READ;
    assign bus.mem_addr  = mem_addr;
    assign bus.mem_din   = bus.din;
`ifdef LIFO_FIFO_CTRL_ALMOST_EN
    assign bus.almost_full  = (count_q >= CNT_W'(AF_LEVEL));
    assign bus.almost_empty = (count_q <= CNT_W'(AE_LEVEL));
`endif
endmodule

// File: tb/tb_lifo_fifo_ctrl.sv
// Directed self-checking bench for lifo_fifo_ctrl (DEPTH=4) with a
// single-port memory model (registered read data).
module tb_lifo_fifo_ctrl;
    localparam int unsigned DEPTH  = 4;
    localparam int unsigned ADDR_W = 4;
    localparam int unsigned DATA_W = 32;
    localparam int unsigned CNT_W  = $clog2(DEPTH + 1);

    logic clk = 1'b0;
    logic reset_n = 1'b0;
    int   checks = 0;
    int   failures = 0;
    logic [DATA_W-1:0] mem [16];

    always #5 clk = ~clk;

    lifo_fifo_ctrl_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .CNT_W(CNT_W)) bus ();

    lifo_fifo_ctrl #(.DEPTH(DEPTH), .ADDR_W(ADDR_W), .DATA_W(DATA_W)) dut (
        .clk_i    (clk),
        .reset_ni (reset_n),
        .bus      (bus)
    );

    // Memory model: write on command, read data appears one cycle later.
    always @(posedge clk) begin
        if (bus.mem_valid) begin
            if (bus.mem_r_w) mem[bus.mem_addr] <= bus.mem_din;
            else             bus.mem_dout <= mem[bus.mem_addr];
        end
    end

    task automatic step;
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset;
        bus.mode = 1'b0; bus.push = 1'b1; bus.pop = 1'b1; bus.clr_err = 1'b0;
        bus.din = 32'hDEAD_BEEF;
        reset_n = 1'b0;
        #12;
        checks++; if (bus.push_rdy !== 1'b0) begin failures++; $display("FAIL rst_push_rdy got=%b exp=0", bus.push_rdy); end
        checks++; if (bus.pop_rdy !== 1'b0) begin failures++; $display("FAIL rst_pop_rdy got=%b exp=0", bus.pop_rdy); end
        checks++; if (bus.mem_valid !== 1'b0) begin failures++; $display("FAIL rst_mem_valid got=%b exp=0", bus.mem_valid); end
        checks++; if (bus.count !== 3'd0) begin failures++; $display("FAIL rst_count got=%0d exp=0", bus.count); end
        checks++; if (bus.empty !== 1'b1 || bus.full !== 1'b0) begin failures++; $display("FAIL rst_flags got empty=%b full=%b exp empty=1 full=0", bus.empty, bus.full); end
        checks++; if (bus.rd_valid !== 1'b0 || bus.ovf !== 1'b0 || bus.udf !== 1'b0) begin failures++; $display("FAIL rst_regs got rd_valid=%b ovf=%b udf=%b exp 0 0 0", bus.rd_valid, bus.ovf, bus.udf); end
`ifdef LIFO_FIFO_CTRL_ALMOST_EN
        checks++; if (bus.almost_full !== 1'b0 || bus.almost_empty !== 1'b1) begin failures++; $display("FAIL rst_almost got af=%b ae=%b exp af=0 ae=1", bus.almost_full, bus.almost_empty); end
`endif
        bus.push = 1'b0; bus.pop = 1'b0;
        @(negedge clk);
        reset_n = 1'b1;
        step();
    endtask

    task automatic test_fifo;
        logic [DATA_W-1:0] d [4];
        d[0] = 32'hA1; d[1] = 32'hB2; d[2] = 32'hC3; d[3] = 32'hD4;
        for (int i = 0; i < 4; i++) begin
            bus.push = 1'b1; bus.din = d[i];
            #1;
            checks++; if (bus.push_rdy !== 1'b1 || bus.mem_addr !== ADDR_W'(i) || bus.mem_r_w !== 1'b1) begin failures++; $display("FAIL fifo_push%0d got rdy=%b addr=%0d rw=%b exp rdy=1 addr=%0d rw=1", i, bus.push_rdy, bus.mem_addr, bus.mem_r_w, i); end
            step();
        end
        bus.din = 32'hE5;
        #1;
        checks++; if (bus.push_rdy !== 1'b0 || bus.mem_valid !== 1'b0) begin failures++; $display("FAIL fifo_push_full got rdy=%b mv=%b exp 0 0", bus.push_rdy, bus.mem_valid); end
        checks++; if (bus.full !== 1'b1 || bus.count !== 3'd4) begin failures++; $display("FAIL fifo_full got full=%b count=%0d exp full=1 count=4", bus.full, bus.count); end
`ifdef LIFO_FIFO_CTRL_ALMOST_EN
        checks++; if (bus.almost_full !== 1'b1 || bus.almost_empty !== 1'b0) begin failures++; $display("FAIL fifo_almost got af=%b ae=%b exp af=1 ae=0", bus.almost_full, bus.almost_empty); end
`endif
        step();
        bus.push = 1'b0;
        checks++; if (bus.ovf !== 1'b1) begin failures++; $display("FAIL fifo_ovf got=%b exp=1", bus.ovf); end
        bus.pop = 1'b1;
        for (int i = 0; i < 4; i++) begin
            #1;
            checks++; if (bus.pop_rdy !== 1'b1 || bus.mem_addr !== ADDR_W'(i) || bus.mem_r_w !== 1'b0) begin failures++; $display("FAIL fifo_pop%0d got rdy=%b addr=%0d rw=%b exp rdy=1 addr=%0d rw=0", i, bus.pop_rdy, bus.mem_addr, bus.mem_r_w, i); end
            step();
            checks++; if (bus.rd_valid !== 1'b1 || bus.rd_data !== d[i]) begin failures++; $display("FAIL fifo_rd%0d got valid=%b data=%h exp valid=1 data=%h", i, bus.rd_valid, bus.rd_data, d[i]); end
        end
        bus.pop = 1'b0;
        step();
        checks++; if (bus.rd_valid !== 1'b0 || bus.empty !== 1'b1) begin failures++; $display("FAIL fifo_drained got valid=%b empty=%b exp valid=0 empty=1", bus.rd_valid, bus.empty); end
        bus.clr_err = 1'b1;
        step();
        bus.clr_err = 1'b0;
        checks++; if (bus.ovf !== 1'b0) begin failures++; $display("FAIL fifo_clr_ovf got=%b exp=0", bus.ovf); end
    endtask

    task automatic test_lifo;
        logic [DATA_W-1:0] d [3];
        d[0] = 32'h11; d[1] = 32'h22; d[2] = 32'h33;
        bus.mode = 1'b1;
        step();
        for (int i = 0; i < 3; i++) begin
            bus.push = 1'b1; bus.din = d[i];
            #1;
            checks++; if (bus.mem_addr !== ADDR_W'(i)) begin failures++; $display("FAIL lifo_push_addr%0d got=%0d exp=%0d", i, bus.mem_addr, i); end
            step();
        end
        bus.push = 1'b0;
        bus.pop = 1'b1;
        for (int i = 0; i < 3; i++) begin
            #1;
            checks++; if (bus.mem_addr !== ADDR_W'(2 - i)) begin failures++; $display("FAIL lifo_pop_addr%0d got=%0d exp=%0d", i, bus.mem_addr, 2 - i); end
            step();
            checks++; if (bus.rd_data !== d[2 - i]) begin failures++; $display("FAIL lifo_rd%0d got=%h exp=%h", i, bus.rd_data, d[2 - i]); end
        end
        bus.pop = 1'b0;
        checks++; if (bus.empty !== 1'b1) begin failures++; $display("FAIL lifo_empty got=%b exp=1", bus.empty); end
        step();
        bus.mode = 1'b0;
        step();
    endtask

    task automatic test_wrap;
        logic [ADDR_W-1:0] a [6];
        a[0] = 4'd0; a[1] = 4'd1; a[2] = 4'd2; a[3] = 4'd3; a[4] = 4'd0; a[5] = 4'd1;
        for (int b = 0; b < 2; b++) begin
            for (int i = 0; i < 3; i++) begin
                bus.push = 1'b1; bus.din = 32'h100 + 32'(3 * b + i);
                #1;
                checks++; if (bus.mem_addr !== a[3 * b + i]) begin failures++; $display("FAIL wrap_push_addr%0d got=%0d exp=%0d", 3 * b + i, bus.mem_addr, a[3 * b + i]); end
                step();
            end
            bus.push = 1'b0;
            bus.pop = 1'b1;
            for (int i = 0; i < 3; i++) begin
                #1;
                checks++; if (bus.mem_addr !== a[3 * b + i]) begin failures++; $display("FAIL wrap_pop_addr%0d got=%0d exp=%0d", 3 * b + i, bus.mem_addr, a[3 * b + i]); end
                step();
                checks++; if (bus.rd_data !== 32'h100 + 32'(3 * b + i)) begin failures++; $display("FAIL wrap_rd%0d got=%h exp=%h", 3 * b + i, bus.rd_data, 32'h100 + 32'(3 * b + i)); end
            end
            bus.pop = 1'b0;
        end
        step();
    endtask

    task automatic test_simultaneous;
        // Pointers enter at wr=rd=2.
        bus.push = 1'b1; bus.pop = 1'b1; bus.din = 32'h77;
        #1;
        checks++; if (bus.push_rdy !== 1'b1 || bus.pop_rdy !== 1'b0 || bus.mem_addr !== 4'd2) begin failures++; $display("FAIL sim_empty got push_rdy=%b pop_rdy=%b addr=%0d exp 1 0 2", bus.push_rdy, bus.pop_rdy, bus.mem_addr); end
        step();
        bus.pop = 1'b0;
        checks++; if (bus.udf !== 1'b1 || bus.count !== 3'd1) begin failures++; $display("FAIL sim_empty_state got udf=%b count=%0d exp udf=1 count=1", bus.udf, bus.count); end
        for (int i = 0; i < 3; i++) begin
            bus.din = 32'h78 + 32'(i);
            step();
        end
        bus.pop = 1'b1;
        #1;
        checks++; if (bus.pop_rdy !== 1'b1 || bus.push_rdy !== 1'b0 || bus.mem_addr !== 4'd2) begin failures++; $display("FAIL sim_full got pop_rdy=%b push_rdy=%b addr=%0d exp 1 0 2", bus.pop_rdy, bus.push_rdy, bus.mem_addr); end
        step();
        bus.push = 1'b0; bus.pop = 1'b0;
        checks++; if (bus.count !== 3'd3 || bus.ovf !== 1'b0 || bus.rd_data !== 32'h77) begin failures++; $display("FAIL sim_full_state got count=%0d ovf=%b data=%h exp 3 0 77", bus.count, bus.ovf, bus.rd_data); end
        bus.clr_err = 1'b1;
        step();
        bus.clr_err = 1'b0;
        checks++; if (bus.udf !== 1'b0) begin failures++; $display("FAIL sim_clr_udf got=%b exp=0", bus.udf); end
        bus.pop = 1'b1;
        for (int i = 0; i < 3; i++) begin
            step();
            checks++; if (bus.rd_data !== 32'h78 + 32'(i)) begin failures++; $display("FAIL sim_drain%0d got=%h exp=%h", i, bus.rd_data, 32'h78 + 32'(i)); end
        end
        bus.pop = 1'b0;
        step();
    endtask

    task automatic test_mode_switch;
        logic [ADDR_W-1:0] a [3];
        a[0] = 4'd2; a[1] = 4'd3; a[2] = 4'd0;
        // Pointers enter at wr=rd=2; leave them at 1 so a clear is visible.
        bus.push = 1'b1;
        for (int i = 0; i < 3; i++) begin
            bus.din = 32'hC0 + 32'(i);
            step();
        end
        bus.push = 1'b0;
        bus.mode = 1'b1;
        step();
        bus.pop = 1'b1;
        for (int i = 0; i < 3; i++) begin
            #1;
            checks++; if (bus.mem_addr !== a[i]) begin failures++; $display("FAIL mode_hold_addr%0d got=%0d exp=%0d", i, bus.mem_addr, a[i]); end
            step();
            checks++; if (bus.rd_data !== 32'hC0 + 32'(i)) begin failures++; $display("FAIL mode_hold_rd%0d got=%h exp=%h", i, bus.rd_data, 32'hC0 + 32'(i)); end
        end
        bus.pop = 1'b0;
        step();
        bus.push = 1'b1; bus.din = 32'h99;
        step();
        bus.din = 32'hAA;
        step();
        bus.push = 1'b0; bus.pop = 1'b1;
        #1;
        checks++; if (bus.mem_addr !== 4'd1) begin failures++; $display("FAIL mode_lifo_addr got=%0d exp=1", bus.mem_addr); end
        step();
        checks++; if (bus.rd_data !== 32'hAA) begin failures++; $display("FAIL mode_lifo_rd got=%h exp=aa", bus.rd_data); end
        step();
        bus.pop = 1'b0; bus.mode = 1'b0;
        checks++; if (bus.rd_data !== 32'h99) begin failures++; $display("FAIL mode_lifo_rd2 got=%h exp=99", bus.rd_data); end
        step();
        bus.push = 1'b1; bus.din = 32'h5A;
        #1;
        checks++; if (bus.mem_addr !== 4'd0) begin failures++; $display("FAIL mode_ptr_clr got=%0d exp=0", bus.mem_addr); end
        step();
        bus.push = 1'b0; bus.pop = 1'b1;
        #1;
        checks++; if (bus.mem_addr !== 4'd0) begin failures++; $display("FAIL mode_rdptr_clr got=%0d exp=0", bus.mem_addr); end
        step();
        bus.pop = 1'b0;
        step();
    endtask

    task automatic test_reset_mid_pop;
        // Pointers enter at wr=rd=1.
        bus.push = 1'b1; bus.din = 32'h66;
        step();
        bus.din = 32'h67;
        step();
        bus.push = 1'b0; bus.pop = 1'b1;
        step();
        bus.pop = 1'b0;
        checks++; if (bus.rd_valid !== 1'b1 || bus.rd_data !== 32'h66) begin failures++; $display("FAIL rmp_pre got valid=%b data=%h exp 1 66", bus.rd_valid, bus.rd_data); end
        #2;
        reset_n = 1'b0;
        #1;
        checks++; if (bus.rd_valid !== 1'b0 || bus.count !== 3'd0 || bus.empty !== 1'b1) begin failures++; $display("FAIL rmp_async got valid=%b count=%0d empty=%b exp 0 0 1", bus.rd_valid, bus.count, bus.empty); end
        #1;
        reset_n = 1'b1;
        step();
        bus.push = 1'b1; bus.din = 32'h55;
        #1;
        checks++; if (bus.push_rdy !== 1'b1 || bus.mem_addr !== 4'd0) begin failures++; $display("FAIL rmp_push got rdy=%b addr=%0d exp 1 0", bus.push_rdy, bus.mem_addr); end
        step();
        bus.push = 1'b0;
        checks++; if (bus.count !== 3'd1) begin failures++; $display("FAIL rmp_count got=%0d exp=1", bus.count); end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        test_reset();
        test_fifo();
        test_lifo();
        test_wrap();
        test_simultaneous();
        test_mode_switch();
        test_reset_mid_pop();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
